// File: rtl/fir_capture_buffer_pkg.sv
// Shared types and constants for the FIR capture buffer slice.
// No logic; the state encoding is fixed so benches can decode it.
package fir_capture_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 14;
    localparam int STEP_VAL   = 7373;

endpackage

// File: rtl/fir_capture_buffer_if.sv
// Random-access read port of the capture buffer: request in, registered data out.
// One-cycle latency, no backpressure; rejected requests simply return rd_valid=0.
interface fir_capture_buffer_if #(
    parameter int DATA_W = fir_capture_buffer_pkg::DATA_W_DEF,
    parameter int ADDR_W = 7
);

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (output rd_en, rd_addr, input rd_data, rd_valid);
    modport slave  (input rd_en, rd_addr, output rd_data, rd_valid);

endinterface

// File: rtl/fir_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Read latency 1; the read register holds its value when re is low.
module fir_capture_ram
    import fir_capture_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 100,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The array itself is never reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fir_capture_buffer.sv
// Arms on request, discards pipeline-fill samples, captures DEPTH samples and tracks the peak.
// Capture advances only on clk_enable; read port has 1-cycle latency, served in IDLE/DONE only.
module fir_capture_buffer
    import fir_capture_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 100,
    parameter int ADDR_W = 7,
    parameter int SKIP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic                     arm,
    input  logic [SKIP_W-1:0]        skip_cycles,
    input  logic signed [DATA_W-1:0] sample_in,
    fir_capture_buffer_if.slave      rd,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] peak
);

    state_t            state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en;
    logic              rd_ok;

    assign wr_en = clk_enable && (state == ST_CAPTURE);
    assign rd_ok = rd.rd_en
                && ((state == ST_IDLE) || (state == ST_DONE))
                && ({1'b0, rd.rd_addr} < (ADDR_W+1)'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
            wr_ptr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            peak     <= '0;
        end else if (clk_enable) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        skip_cnt <= skip_cycles;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state    <= (skip_cycles == '0) ? ST_CAPTURE : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    // The arm cycle itself is the first discarded sample.
                    skip_cnt <= skip_cnt - SKIP_W'(1);
                    if (skip_cnt <= SKIP_W'(2)) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if ((wr_ptr == '0) || (sample_in > peak)) begin
                        peak <= sample_in;
                    end
                    if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
                        wr_ptr <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd.rd_valid <= 1'b0;
        end else begin
            rd.rd_valid <= rd_ok;
        end
    end

    fir_capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (sample_in),
        .re    (rd_ok),
        .raddr (rd.rd_addr),
        .rdata (rd.rd_data)
    );

endmodule
